// File: rtl/result_pipe.sv
// Per-pipe result staging buffer: tracks in-flight instructions through stages 1..7,
// captures unit results at their latency stage and drives a registered write-back port.
module result_pipe #(
    parameter int unsigned REG_DATA_WD = 128,
    parameter int unsigned N_UNIT      = 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  issue_vld,
    input  logic                                  issue_wr,
    input  logic [6:0]                            issue_addr,
    input  logic [2:0]                            issue_idx,
    input  logic [2:0]                            issue_lat,
    input  logic                                  flush,
    input  logic [N_UNIT-1:0][REG_DATA_WD-1:0]    unit_res,
    output logic [6:0]                            rf_addr_s2,
    output logic [6:0]                            rf_addr_s3,
    output logic [6:0]                            rf_addr_s4,
    output logic [6:0]                            rf_addr_s5,
    output logic [6:0]                            rf_addr_s6,
    output logic [6:0]                            rf_addr_s7,
    output logic [REG_DATA_WD-1:0]                rf_data_s2,
    output logic [REG_DATA_WD-1:0]                rf_data_s3,
    output logic [REG_DATA_WD-1:0]                rf_data_s4,
    output logic [REG_DATA_WD-1:0]                rf_data_s5,
    output logic [REG_DATA_WD-1:0]                rf_data_s6,
    output logic [REG_DATA_WD-1:0]                rf_data_s7,
    output logic [2:0]                            rf_idx_s2,
    output logic [2:0]                            rf_idx_s3,
    output logic [2:0]                            rf_idx_s4,
    output logic [2:0]                            rf_idx_s5,
    output logic [2:0]                            rf_idx_s6,
    output logic [2:0]                            rf_idx_s7,
    output logic                                  rf_wr_wb,
    output logic [6:0]                            rf_addr_wb,
    output logic [REG_DATA_WD-1:0]                rf_data_wb
);

    logic [7:1]             vld_q, vld_d;
    logic [7:1]             wr_q, wr_d;
    logic [6:0]             addr_q [1:7];
    logic [6:0]             addr_d [1:7];
    logic [2:0]             idx_q  [1:7];
    logic [2:0]             idx_d  [1:7];
    logic [2:0]             lat_q  [1:7];
    logic [2:0]             lat_d  [1:7];
    logic [REG_DATA_WD-1:0] data_q [1:7];
    logic [REG_DATA_WD-1:0] data_d [1:7];

    logic                   wb_wr_q, wb_wr_d;
    logic [6:0]             wb_addr_q, wb_addr_d;
    logic [REG_DATA_WD-1:0] wb_data_q, wb_data_d;

    logic [2:0]             rdy_idx [2:7];

    always_comb begin
        // idx 0 cannot produce a result, so such an entry is demoted to a non-writer
        vld_d[1]  = issue_vld & ~flush;
        wr_d[1]   = issue_wr & (issue_idx != 3'd0);
        addr_d[1] = issue_addr;
        idx_d[1]  = issue_idx;
        lat_d[1]  = (issue_lat < 3'd2) ? 3'd2 : issue_lat;
        data_d[1] = '0;
        for (int unsigned k = 2; k <= 7; k++) begin
            vld_d[k]  = vld_q[k-1];
            wr_d[k]   = wr_q[k-1];
            addr_d[k] = addr_q[k-1];
            idx_d[k]  = idx_q[k-1];
            lat_d[k]  = lat_q[k-1];
            data_d[k] = (vld_q[k-1] && wr_q[k-1] && (lat_q[k-1] == 3'(k)))
                        ? unit_res[idx_q[k-1]] : data_q[k-1];
        end
        // flush also kills the entry leaving stage 1
        vld_d[2]  = vld_q[1] & ~flush;

        wb_wr_d   = vld_q[7] & wr_q[7];
        wb_addr_d = wb_wr_d ? addr_q[7] : wb_addr_q;
        wb_data_d = wb_wr_d ? data_q[7] : wb_data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q     <= '0;
            wr_q      <= '0;
            addr_q    <= '{default: '0};
            idx_q     <= '{default: '0};
            lat_q     <= '{default: '0};
            data_q    <= '{default: '0};
            wb_wr_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            vld_q     <= vld_d;
            wr_q      <= wr_d;
            addr_q    <= addr_d;
            idx_q     <= idx_d;
            lat_q     <= lat_d;
            data_q    <= data_d;
            wb_wr_q   <= wb_wr_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    always_comb begin
        for (int unsigned k = 2; k <= 7; k++) begin
            rdy_idx[k] = (vld_q[k] && wr_q[k] && (lat_q[k] <= 3'(k))) ? idx_q[k] : 3'd0;
        end
    end

    assign rf_addr_s2 = addr_q[2];
    assign rf_addr_s3 = addr_q[3];
    assign rf_addr_s4 = addr_q[4];
    assign rf_addr_s5 = addr_q[5];
    assign rf_addr_s6 = addr_q[6];
    assign rf_addr_s7 = addr_q[7];

    assign rf_data_s2 = data_q[2];
    assign rf_data_s3 = data_q[3];
    assign rf_data_s4 = data_q[4];
    assign rf_data_s5 = data_q[5];
    assign rf_data_s6 = data_q[6];
    assign rf_data_s7 = data_q[7];

    assign rf_idx_s2  = rdy_idx[2];
    assign rf_idx_s3  = rdy_idx[3];
    assign rf_idx_s4  = rdy_idx[4];
    assign rf_idx_s5  = rdy_idx[5];
    assign rf_idx_s6  = rdy_idx[6];
    assign rf_idx_s7  = rdy_idx[7];

    assign rf_wr_wb   = wb_wr_q;
    assign rf_addr_wb = wb_addr_q;
    assign rf_data_wb = wb_data_q;

endmodule
